// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// States, port ids and the default access length.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  localparam int WAIT_CYCLES_DEF = 3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and SRAM-side signals of the arbiter.
// slave is the arbiter's view, master is the environment's view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);

  logic [1:0]        Req;
  logic [1:0]        Wr;
  logic [ADDR_W-1:0] Addr0;
  logic [ADDR_W-1:0] Addr1;
  logic [DATA_W-1:0] WData0;
  logic [DATA_W-1:0] WData1;
  logic [DATA_W-1:0] RData0;
  logic [DATA_W-1:0] RData1;
  logic [1:0]        Done;
  logic              Busy;

  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [DATA_W-1:0] SRAM_DQ_OUT;
  logic              SRAM_DQ_OE;
  logic [DATA_W-1:0] SRAM_DQ_IN;
  logic              SRAM_CE_N;
  logic              SRAM_OE_N;
  logic              SRAM_WE_N;
  logic              SRAM_UB_N;
  logic              SRAM_LB_N;

  modport slave (
    input  Req, Wr, Addr0, Addr1,
    input  WData0, WData1, SRAM_DQ_IN,
    output RData0, RData1, Done, Busy,
    output SRAM_ADDR, SRAM_DQ_OUT,
    output SRAM_DQ_OE, SRAM_CE_N,
    output SRAM_OE_N, SRAM_WE_N,
    output SRAM_UB_N, SRAM_LB_N
  );

  modport master (
    output Req, Wr, Addr0, Addr1,
    output WData0, WData1, SRAM_DQ_IN,
    input  RData0, RData1, Done, Busy,
    input  SRAM_ADDR, SRAM_DQ_OUT,
    input  SRAM_DQ_OE, SRAM_CE_N,
    input  SRAM_OE_N, SRAM_WE_N,
    input  SRAM_UB_N, SRAM_LB_N
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer moves
// away from whichever port was last accepted.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) ptr_d = gnt_o[0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-length SRAM access sequencer shared by the
// CPU port and a secondary master, round-robin arbitrated.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input logic           Clk,
  input logic           Reset_n,
  mem_arbiter_if.slave  bus
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;
  logic              id_q, id_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [1:0]        gnt;
  logic              accept;
  logic              acc;

  rr_arb2 u_rr (
    .clk_i    (Clk),
    .rst_ni   (Reset_n),
    .req_i    (bus.Req),
    .accept_i (accept),
    .gnt_o    (gnt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_d     = wr_q;
    id_d     = id_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    accept   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.Req) begin
          accept  = 1'b1;
          id_d    = gnt[PORT_AUX];
          state_d = ACCESS;
          cnt_d   = CNT_LOAD;
          if (id_d == PORT_AUX) begin
            addr_d = bus.Addr1;
            data_d = bus.WData1;
            wr_d   = bus.Wr[1];
          end else begin
            addr_d = bus.Addr0;
            data_d = bus.WData0;
            wr_d   = bus.Wr[0];
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          cnt_d   = 4'd0;
          // Read data is sampled at the end of the last strobe cycle.
          if (!wr_q) begin
            if (id_q == PORT_AUX) rdata1_d = bus.SRAM_DQ_IN;
            else                  rdata0_d = bus.SRAM_DQ_IN;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      id_q     <= PORT_CPU;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
      id_q     <= id_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign acc = (state_q == ACCESS);

  assign bus.SRAM_CE_N   = ~acc;
  assign bus.SRAM_UB_N   = ~acc;
  assign bus.SRAM_LB_N   = ~acc;
  assign bus.SRAM_OE_N   = ~(acc & ~wr_q);
  assign bus.SRAM_WE_N   = ~(acc & wr_q);
  assign bus.SRAM_DQ_OE  = acc & wr_q;
  assign bus.SRAM_ADDR   = addr_q;
  assign bus.SRAM_DQ_OUT = data_q;
  assign bus.Busy        = (state_q != IDLE);
  assign bus.RData0      = rdata0_q;
  assign bus.RData1      = rdata1_q;
  assign bus.Done        = (state_q != DONE) ? 2'b00 :
                           (id_q == PORT_AUX) ? 2'b10 : 2'b01;

endmodule
